// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one signed MAC steps over N taps per ce; y_valid N+3 cycles after an accepted ce.
// A ce that arrives while busy is dropped and latches overrun; coefficients are ping-pong banked.
module fir_mac_sequencer #(
  parameter int N      = 39,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_swap,
  output logic                     swap_done
);

  localparam int PTR_W  = $clog2(N);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [PTR_W-1:0] TAP_LAST = PTR_W'(N - 1);
  localparam logic [6:0]       N_ADDR   = 7'(N);
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_ROUND, S_OUT} state_t;
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] delay [N];
  logic signed [COEF_W-1:0] bank0 [N];
  logic signed [COEF_W-1:0] bank1 [N];
  logic                     bank_sel;
  logic                     swap_pend;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  logic                     exchange, wr_to_bank1, coef_wr_ok;
  logic [PTR_W-1:0]         coef_waddr;
  logic signed [COEF_W-1:0] coef_act;
  logic signed [ACC_W-1:0]  acc_rnd, acc_shr;
  logic signed [DATA_W-1:0] y_sat;

  // Banks may only exchange between samples so no sample mixes two coefficient sets.
  assign exchange    = swap_pend && (((state == S_IDLE) && !ce) || (state == S_OUT));
  assign wr_to_bank1 = exchange ? bank_sel : !bank_sel;
  assign coef_wr_ok  = coef_we && ({1'b0, coef_addr} < N_ADDR);
  assign coef_waddr  = coef_addr[PTR_W-1:0];
  assign coef_act    = bank_sel ? bank1[tap] : bank0[tap];
  assign busy        = (state != S_IDLE);
  assign swap_done   = exchange;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ce) state_nxt = S_MAC;
      S_MAC:   if (tap == TAP_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    acc_rnd = acc + RND;
    acc_shr = acc_rnd >>> FRAC;
    if (acc_shr > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (acc_shr < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
    else                      y_sat = acc_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      y_out     <= '0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
      bank_sel  <= 1'b0;
      swap_pend <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tap       <= '0;
      prod      <= '0;
      acc       <= '0;
      for (int i = 0; i < N; i++) begin
        delay[i] <= '0;
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      y_valid <= (state == S_ROUND);
      if (ce && (state != S_IDLE)) overrun <= 1'b1;

      case (state)
        S_IDLE: if (ce) begin
          delay[wr_ptr] <= x_in;
          rd_ptr        <= wr_ptr;
          tap           <= '0;
          acc           <= '0;
          prod          <= '0;
        end
        // Product is pipelined one cycle ahead of the accumulate.
        S_MAC: begin
          prod   <= PROD_W'(coef_act) * PROD_W'(delay[rd_ptr]);
          acc    <= acc + ACC_W'(prod);
          tap    <= tap + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? TAP_LAST : rd_ptr - 1'b1;
        end
        S_DRAIN: acc   <= acc + ACC_W'(prod);
        S_ROUND: y_out <= y_sat;
        S_OUT:   wr_ptr <= (wr_ptr == TAP_LAST) ? '0 : wr_ptr + 1'b1;
        default: ;
      endcase

      if (exchange) begin
        bank_sel  <= !bank_sel;
        swap_pend <= 1'b0;
      end else if (coef_swap) begin
        swap_pend <= 1'b1;
      end

      if (coef_wr_ok) begin
        if (wr_to_bank1) bank1[coef_waddr] <= coef_wdata;
        else             bank0[coef_waddr] <= coef_wdata;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: table vectors, directed corner sequences, and random samples
// compared against a direct convolution model of the last N accepted samples.
module tb_fir_mac_sequencer;

  localparam int N = 39;

  logic        clk = 1'b0;
  logic        reset_n, ce, coef_we, coef_swap;
  logic [15:0] x_in, coef_wdata;
  logic [5:0]  coef_addr;
  logic [15:0] y_out;
  logic        y_valid, busy, overrun, swap_done;

  always #10 clk = ~clk;

  fir_mac_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .x_in(x_in), .y_out(y_out),
    .y_valid(y_valid), .busy(busy), .overrun(overrun), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
    .swap_done(swap_done)
  );

  int checks = 0;
  int errors = 0;

  // Model state: hist[0] is the newest accepted sample.
  int hist [N];
  int m_act [N];
  int m_sh [N];

  // Results of the last run_sample call.
  logic [15:0] r_y;
  int          r_lat, r_nvld;
  logic        r_sd, r_bo, r_ba;

  typedef struct {
    logic [15:0] coef;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < N; i++) begin
      hist[i] = 0; m_act[i] = 0; m_sh[i] = 0;
    end
  endtask

  task automatic model_push(input logic [15:0] x);
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'($signed(x));
  endtask

  task automatic model_swap;
    int t;
    for (int i = 0; i < N; i++) begin
      t = m_act[i]; m_act[i] = m_sh[i]; m_sh[i] = t;
    end
  endtask

  function automatic logic [15:0] model_y();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(m_act[k]) * longint'(hist[k]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic do_reset;
    reset_n = 1'b0; ce = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    model_clear;
  endtask

  task automatic wr_coef(input int a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = 6'(a); coef_wdata = d;
    tick;
    coef_we = 1'b0;
    if (a < N) m_sh[a] = int'($signed(d));
  endtask

  task automatic swap_idle(input string nm);
    coef_swap = 1'b1;
    tick;
    chk(nm, swap_done, 1);
    coef_swap = 1'b0;
    tick;
    model_swap;
  endtask

  // Swap request followed by a write landing in the exchange cycle itself.
  task automatic swap_with_write(input int a, input logic [15:0] d);
    coef_swap = 1'b1;
    tick;
    coef_swap = 1'b0;
    chk("swap_wr_done", swap_done, 1);
    coef_we = 1'b1; coef_addr = 6'(a); coef_wdata = d;
    tick;
    coef_we = 1'b0;
    model_swap;
    m_sh[a] = int'($signed(d));
  endtask

  task automatic run_sample(input logic [15:0] x, input int dup_at, input logic [15:0] dup_x,
                            input int swap_at);
    r_lat = 0; r_nvld = 0; r_sd = 1'b0; r_y = '0; r_bo = 1'b0; r_ba = 1'b1;
    x_in = x; ce = 1'b1;
    tick;
    ce = 1'b0;
    for (int cyc = 1; cyc <= N + 8; cyc++) begin
      if (y_valid) begin
        r_nvld++;
        if (r_lat == 0) begin
          r_lat = cyc; r_y = y_out; r_sd = swap_done; r_bo = busy;
        end
      end
      if (r_lat != 0 && cyc == r_lat + 1) r_ba = busy;
      ce = (cyc == dup_at);
      if (ce) x_in = dup_x;
      coef_swap = (cyc == swap_at);
      tick;
    end
    ce = 1'b0; coef_swap = 1'b0;
  endtask

  task automatic sample_chk(input string nm, input logic [15:0] x);
    logic [15:0] exp;
    model_push(x);
    exp = model_y();
    run_sample(x, 0, 16'h0, 0);
    chk(nm, r_y, exp);
    chk({nm, "_vld"}, r_nvld, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [15:0] d;

    vt[0] = '{16'h7FFF, 16'h1234, 16'h1234};
    vt[1] = '{16'h4000, 16'h1000, 16'h0800};
    vt[2] = '{16'h4000, 16'h0003, 16'h0002};
    vt[3] = '{16'h4000, 16'hFFFD, 16'hFFFF};
    vt[4] = '{16'h8000, 16'h8000, 16'h7FFF};
    vt[5] = '{16'h8000, 16'h1234, 16'hEDCC};
    vt[6] = '{16'h2000, 16'h0002, 16'h0001};
    vt[7] = '{16'h7FFF, 16'h7FFF, 16'h7FFE};

    reset_n = 1'b0; ce = 1'b0; x_in = '0; coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; coef_swap = 1'b0;
    model_clear;
    tick; tick;
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_swap_done", swap_done, 0);
    reset_n = 1'b1;
    tick;

    // Single-tap vectors: only tap 0 is ever nonzero in the active bank.
    for (int i = 0; i < 8; i++) begin
      wr_coef(0, vt[i].coef);
      swap_idle("vec_swap");
      model_push(vt[i].x);
      run_sample(vt[i].x, 0, 16'h0, 0);
      chk("vec_y", r_y, vt[i].y);
      chk("vec_nvld", r_nvld, 1);
      if (i == 0) begin
        chk("latency", r_lat, N + 3);
        chk("busy_in_out", r_bo, 1);
        chk("busy_after", r_ba, 0);
        chk("no_overrun", overrun, 0);
      end
    end

    // Delay: impulse through tap 5, 100 samples so the pointers wrap.
    do_reset;
    wr_coef(5, 16'h4000);
    swap_idle("dly_swap");
    for (int i = 0; i < 100; i++) begin
      run_sample((i == 0) ? 16'h2000 : 16'h0000, 0, 16'h0, 0);
      chk("dly_y", r_y, (i == 5) ? 16'h1000 : 16'h0000);
    end

    // Saturation both directions.
    do_reset;
    for (int k = 0; k < N; k++) wr_coef(k, 16'h7FFF);
    swap_idle("sat_swap");
    for (int i = 0; i < N; i++) sample_chk("sat_pos", 16'h7FFF);
    chk("sat_pos_final", r_y, 16'h7FFF);
    for (int i = 0; i < N; i++) sample_chk("sat_neg", 16'h8000);
    chk("sat_neg_final", r_y, 16'h8000);

    // Overrun: second ce 10 cycles in is dropped.
    do_reset;
    wr_coef(0, 16'h7FFF);
    wr_coef(1, 16'h7FFF);
    swap_idle("ovr_swap");
    chk("ovr_clear", overrun, 0);
    model_push(16'h0100);
    d = model_y();
    run_sample(16'h0100, 10, 16'h0700, 0);
    chk("ovr_y", r_y, d);
    chk("ovr_nvld", r_nvld, 1);
    chk("ovr_set", overrun, 1);
    sample_chk("ovr_next", 16'h0010);
    chk("ovr_next_hard", r_y, 16'h0110);
    chk("ovr_sticky", overrun, 1);

    // Swap timing: request during MAC exchanges with that sample's y_valid.
    do_reset;
    wr_coef(0, 16'h7FFF);
    swap_idle("sw_idle1");
    wr_coef(0, 16'h4000);
    model_push(16'h1000);
    run_sample(16'h1000, 0, 16'h0, 10);
    chk("sw_old_bank", r_y, 16'h1000);
    chk("sw_with_vld", r_sd, 1);
    model_swap;
    model_push(16'h1000);
    run_sample(16'h1000, 0, 16'h0, 0);
    chk("sw_new_bank", r_y, 16'h0800);
    chk("sw_no_repeat", r_sd, 0);
    swap_with_write(0, 16'h2000);
    swap_idle("sw_idle2");
    sample_chk("sw_wr_bank", 16'h0002);
    chk("sw_wr_bank_hard", r_y, 16'h0001);

    // Reset mid-MAC.
    do_reset;
    wr_coef(0, 16'h7FFF);
    swap_idle("rm_swap");
    sample_chk("rm_pre", 16'h1234);
    x_in = 16'h4321; ce = 1'b1;
    tick;
    ce = 1'b0;
    for (int c = 1; c < 20; c++) tick;
    reset_n = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_y_out", y_out, 0);
    chk("rm_y_valid", y_valid, 0);
    tick; tick;
    reset_n = 1'b1;
    model_clear;
    cnt = 0;
    for (int c = 0; c < N + 8; c++) begin
      if (y_valid) cnt++;
      tick;
    end
    chk("rm_no_vld", cnt, 0);
    wr_coef(1, 16'h7FFF);
    swap_idle("rm_swap2");
    sample_chk("rm_zero_line", 16'h0555);
    chk("rm_zero_hard", r_y, 16'h0000);
    sample_chk("rm_tap1", 16'h0000);
    chk("rm_tap1_hard", r_y, 16'h0555);

    // Random coefficient sets and samples.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        if (r == 0) d = 16'(int'($urandom_range(0, 4095)) - 2048);
        else        d = 16'($urandom);
        wr_coef(k, d);
      end
      wr_coef(63, 16'($urandom));
      swap_idle("rnd_swap");
      for (int i = 0; i < 40; i++) sample_chk("rnd_y", 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
